// File: rtl/trg_pkg.sv
// Shared definitions for the trigger-latency timer and its run-control
// sequencer: sequencer state encoding, timer width, minimum-statistic seed
// and a bitwise majority vote for the redundant counter.
package trg_pkg;

  localparam int TRG_TIME_W = 8;
  localparam logic [TRG_TIME_W-1:0] MIN_INIT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_TIMING,
    ST_CAPTURE,
    ST_HOLD,
    ST_DONE
  } trg_seq_state_t;

  function automatic logic [TRG_TIME_W-1:0] maj3(
    input logic [TRG_TIME_W-1:0] a,
    input logic [TRG_TIME_W-1:0] b,
    input logic [TRG_TIME_W-1:0] c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/trg_timer.sv
// START-to-STOP latency timer.
//   CLK, RST_N : clock, asynchronous active-low reset
//   HOLDOFF    : holds the counter idle and cleared, START ignored
//   START      : begins counting from 0
//   STOP       : latches the running count into TIME
//   CLR        : synchronous clear of counter and TIME
//   TIME       : latency of the last START/STOP pair (STOP edge - START edge - 1)
// TMR=1 triplicates the counter and running flag with a majority vote.
module trg_timer
  import trg_pkg::*;
#(
  parameter int TMR = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  HOLDOFF,
  input  logic                  START,
  input  logic                  STOP,
  input  logic                  CLR,
  output logic [TRG_TIME_W-1:0] TIME
);

  logic [2:0][TRG_TIME_W-1:0] cnt;
  logic [2:0]                 run;
  logic [TRG_TIME_W-1:0]      cnt_v;
  logic                       run_v;

  always_comb begin
    if (TMR != 0) begin
      cnt_v = maj3(cnt[0], cnt[1], cnt[2]);
      run_v = (run[0] & run[1]) | (run[0] & run[2]) | (run[1] & run[2]);
    end else begin
      cnt_v = cnt[0];
      run_v = run[0];
    end
  end

  // Every copy reloads from the voted value, so a single upset is scrubbed
  // on the next edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt  <= '0;
      run  <= '0;
      TIME <= '0;
    end else if (CLR) begin
      cnt  <= '0;
      run  <= '0;
      TIME <= '0;
    end else if (HOLDOFF) begin
      cnt <= '0;
      run <= '0;
    end else if (START) begin
      cnt <= '0;
      run <= '1;
    end else if (run_v) begin
      if (STOP) begin
        TIME <= cnt_v;
        run  <= '0;
      end else if (cnt_v != '1) begin
        cnt <= {3{cnt_v + TRG_TIME_W'(1)}};
      end
    end
  end

endmodule

// File: rtl/trg_timer_seq.sv
// Run-control sequencer for one trg_timer: arms the timer, forces a STOP on
// timeout, and accumulates latency statistics.
//   CLK, RST_N          : clock, asynchronous active-low reset
//   ENABLE              : run measurements while high
//   NSAMP_REQ           : samples per run (0 = run forever)
//   CLR_STATS           : pulse, clears statistics and the timer output
//   TRG_START, TRG_STOP : start / stop trigger pulses
//   BUSY, DONE          : run status
//   LAST/MIN/MAX_TIME   : latency statistics over valid samples
//   NSAMP, NTMO         : valid-sample and timeout counts (saturating)
module trg_timer_seq
  import trg_pkg::*;
#(
  parameter int                    TMR         = 0,
  parameter logic [TRG_TIME_W-1:0] TIMEOUT     = 8'd250,
  parameter int                    HOLDOFF_CYC = 4,
  parameter int                    CNT_W       = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ENABLE,
  input  logic [CNT_W-1:0]      NSAMP_REQ,
  input  logic                  CLR_STATS,
  input  logic                  TRG_START,
  input  logic                  TRG_STOP,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [TRG_TIME_W-1:0] LAST_TIME,
  output logic [TRG_TIME_W-1:0] MIN_TIME,
  output logic [TRG_TIME_W-1:0] MAX_TIME,
  output logic [CNT_W-1:0]      NSAMP,
  output logic [CNT_W-1:0]      NTMO
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLDOFF_CYC - 1);

  trg_seq_state_t        state, nxt;
  logic [TRG_TIME_W-1:0] shadow;
  logic [3:0]            hcnt;
  logic                  valid;
  logic                  done_seen;
  logic                  hold_last;
  logic                  force_stop;
  logic                  tmr_holdoff, tmr_start, tmr_stop, tmr_clr;
  logic [TRG_TIME_W-1:0] tmr_time;

  assign hold_last   = (hcnt == HOLD_LAST);
  assign force_stop  = (state == ST_TIMING) && ENABLE && !TRG_STOP && (shadow == TIMEOUT);
  assign tmr_holdoff = (state == ST_IDLE) || (state == ST_HOLD) || (state == ST_DONE);
  assign tmr_start   = TRG_START && (state == ST_ARMED);
  assign tmr_stop    = (TRG_STOP && (state == ST_TIMING)) || force_stop;
  assign tmr_clr     = CLR_STATS || !RST_N;

  trg_timer #(.TMR(TMR)) u_timer (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .HOLDOFF (tmr_holdoff),
    .START   (tmr_start),
    .STOP    (tmr_stop),
    .CLR     (tmr_clr),
    .TIME    (tmr_time)
  );

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:    if (ENABLE) nxt = ST_ARMED;
      ST_ARMED:   if (!ENABLE) nxt = ST_HOLD;
                  else if (TRG_START) nxt = ST_TIMING;
      ST_TIMING:  if (!ENABLE) nxt = ST_HOLD;
                  else if (TRG_STOP || shadow == TIMEOUT) nxt = ST_CAPTURE;
      ST_CAPTURE: nxt = ST_HOLD;
      ST_HOLD:    if (hold_last) begin
                    if (NSAMP_REQ != '0 && NSAMP == NSAMP_REQ) nxt = ST_DONE;
                    else if (!ENABLE) nxt = ST_IDLE;
                    else nxt = ST_ARMED;
                  end
      ST_DONE:    if (!ENABLE) nxt = ST_IDLE;
      default:    nxt = ST_IDLE;
    endcase
  end

  // BUSY/DONE are registered from the next state so they line up with it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      shadow    <= '0;
      hcnt      <= '0;
      valid     <= 1'b0;
      done_seen <= 1'b0;
      LAST_TIME <= '0;
      MIN_TIME  <= MIN_INIT;
      MAX_TIME  <= '0;
      NSAMP     <= '0;
      NTMO      <= '0;
    end else begin
      state <= nxt;
      BUSY  <= !(nxt == ST_IDLE || nxt == ST_DONE);
      DONE  <= (nxt == ST_DONE);
      valid <= (state == ST_TIMING) && TRG_STOP;

      if (state == ST_ARMED)       shadow <= '0;
      else if (state == ST_TIMING) shadow <= shadow + TRG_TIME_W'(1);

      if (state != ST_HOLD) hcnt <= '0;
      else if (!hold_last)  hcnt <= hcnt + 4'd1;

      if (nxt == ST_DONE)                   done_seen <= 1'b1;
      else if (state == ST_IDLE && ENABLE)  done_seen <= 1'b0;

      if (CLR_STATS) begin
        LAST_TIME <= '0;
        MIN_TIME  <= MIN_INIT;
        MAX_TIME  <= '0;
        NSAMP     <= '0;
        NTMO      <= '0;
      end else if (state == ST_IDLE && ENABLE && done_seen) begin
        NSAMP <= '0;
        NTMO  <= '0;
      end else if (state == ST_CAPTURE) begin
        if (valid) begin
          LAST_TIME <= tmr_time;
          if (tmr_time < MIN_TIME) MIN_TIME <= tmr_time;
          if (tmr_time > MAX_TIME) MAX_TIME <= tmr_time;
          if (NSAMP != '1) NSAMP <= NSAMP + CNT_W'(1);
        end else if (NTMO != '1) begin
          NTMO <= NTMO + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_trg_timer_seq.sv
module tb_trg_timer_seq;

  localparam int TO = 20;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        ENABLE;
  logic [15:0] NSAMP_REQ;
  logic        CLR_STATS;
  logic        TRG_START;
  logic        TRG_STOP;
  logic        BUSY, DONE;
  logic [7:0]  LAST_TIME, MIN_TIME, MAX_TIME;
  logic [15:0] NSAMP, NTMO;

  int total = 0;
  int bad   = 0;

  // Reference statistics, maintained per completed sample.
  int e_last, e_min, e_max, e_n, e_t;

  typedef struct {
    int d;      // STOP edge minus START edge
    int last;
    int mn;
    int mx;
    int n;
    bit done;
  } vec_t;
  vec_t tbl[3];

  trg_timer_seq #(
    .TMR         (0),
    .TIMEOUT     (8'd20),
    .HOLDOFF_CYC (4),
    .CNT_W       (16)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .ENABLE    (ENABLE),
    .NSAMP_REQ (NSAMP_REQ),
    .CLR_STATS (CLR_STATS),
    .TRG_START (TRG_START),
    .TRG_STOP  (TRG_STOP),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .LAST_TIME (LAST_TIME),
    .MIN_TIME  (MIN_TIME),
    .MAX_TIME  (MAX_TIME),
    .NSAMP     (NSAMP),
    .NTMO      (NTMO)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    e_last = 0; e_min = 255; e_max = 0; e_n = 0; e_t = 0;
  endtask

  task automatic model_sample(input int d, input bit tmo);
    if (tmo) begin
      e_t++;
    end else begin
      e_last = d - 1;
      if (e_last < e_min) e_min = e_last;
      if (e_last > e_max) e_max = e_last;
      e_n++;
    end
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, ".last"},  32'(LAST_TIME), 32'(e_last));
    chk({tag, ".min"},   32'(MIN_TIME),  32'(e_min));
    chk({tag, ".max"},   32'(MAX_TIME),  32'(e_max));
    chk({tag, ".nsamp"}, 32'(NSAMP),     32'(e_n));
    chk({tag, ".ntmo"},  32'(NTMO),      32'(e_t));
  endtask

  // Called with the sequencer armed; returns once it is armed again
  // (or has settled in DONE/IDLE), six cycles after the STOP/forced-stop edge.
  task automatic run_sample(input int d, input bit tmo);
    TRG_START = 1'b1; tick(); TRG_START = 1'b0;
    if (tmo) begin
      repeat (TO + 1) tick();
    end else begin
      repeat (d - 1) tick();
      TRG_STOP = 1'b1; tick(); TRG_STOP = 1'b0;
    end
    repeat (6) tick();
    model_sample(d, tmo);
  endtask

  initial begin
    tbl[0] = '{d: 11, last: 10, mn: 10, mx: 10, n: 1, done: 1'b0};
    tbl[1] = '{d:  4, last:  3, mn:  3, mx: 10, n: 2, done: 1'b0};
    tbl[2] = '{d:  8, last:  7, mn:  3, mx: 10, n: 3, done: 1'b1};

    RST_N = 1'b0; ENABLE = 1'b0; NSAMP_REQ = '0; CLR_STATS = 1'b0;
    TRG_START = 1'b0; TRG_STOP = 1'b0;
    model_reset();
    repeat (3) tick();
    chk_stats("reset");
    chk("reset.busy", 32'(BUSY), 0);
    chk("reset.done", 32'(DONE), 0);
    RST_N = 1'b1;
    tick();

    // Single sample, latency 5, run of one.
    NSAMP_REQ = 16'd1; ENABLE = 1'b1; tick();
    TRG_START = 1'b1; tick(); TRG_START = 1'b0;
    repeat (5) tick();
    TRG_STOP = 1'b1; tick(); TRG_STOP = 1'b0;
    repeat (4) tick();
    chk("t1.done_early", 32'(DONE), 0);
    chk("t1.busy_early", 32'(BUSY), 1);
    tick();
    chk("t1.done", 32'(DONE), 1);
    chk("t1.busy", 32'(BUSY), 0);
    model_sample(6, 1'b0);
    chk_stats("t1");
    ENABLE = 1'b0; tick();
    chk("t1.done_off", 32'(DONE), 0);

    // Three-sample run from the table.
    CLR_STATS = 1'b1; tick(); CLR_STATS = 1'b0;
    model_reset();
    NSAMP_REQ = 16'd3; ENABLE = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      run_sample(tbl[i].d, 1'b0);
      chk("t2.last",  32'(LAST_TIME), 32'(tbl[i].last));
      chk("t2.min",   32'(MIN_TIME),  32'(tbl[i].mn));
      chk("t2.max",   32'(MAX_TIME),  32'(tbl[i].mx));
      chk("t2.nsamp", 32'(NSAMP),     32'(tbl[i].n));
      chk("t2.ntmo",  32'(NTMO),      0);
      chk("t2.done",  32'(DONE),      32'(tbl[i].done));
    end
    ENABLE = 1'b0; tick();

    // Timeout: forced stop on the edge after the shadow count reaches 20.
    NSAMP_REQ = '0; ENABLE = 1'b1; tick();
    e_n = 0; e_t = 0;
    TRG_START = 1'b1; tick(); TRG_START = 1'b0;
    repeat (TO) tick();
    chk("t3.ntmo_pre", 32'(NTMO), 0);
    tick();
    chk("t3.ntmo_cap", 32'(NTMO), 0);
    tick();
    model_sample(0, 1'b1);
    chk_stats("t3");
    repeat (5) tick();

    // START and STOP together while armed: START wins.
    TRG_START = 1'b1; TRG_STOP = 1'b1; tick();
    TRG_START = 1'b0; TRG_STOP = 1'b0; tick();
    TRG_STOP = 1'b1; tick(); TRG_STOP = 1'b0;
    repeat (6) tick();
    model_sample(2, 1'b0);
    chk_stats("t4");

    // Abort mid-timing.
    TRG_START = 1'b1; tick(); TRG_START = 1'b0;
    repeat (3) tick();
    ENABLE = 1'b0; tick();
    repeat (3) tick();
    chk("t5.busy_hold", 32'(BUSY), 1);
    tick();
    chk("t5.busy_idle", 32'(BUSY), 0);
    chk("t5.done", 32'(DONE), 0);
    chk_stats("t5");

    // CLR_STATS in the capture cycle.
    ENABLE = 1'b1; tick();
    TRG_START = 1'b1; tick(); TRG_START = 1'b0;
    repeat (4) tick();
    TRG_STOP = 1'b1; tick(); TRG_STOP = 1'b0;
    CLR_STATS = 1'b1; tick(); CLR_STATS = 1'b0;
    model_reset();
    chk_stats("t6");
    repeat (5) tick();

    // Random samples, including STOP on the timeout cycle (d = TO + 1).
    for (int k = 0; k < 24; k++) begin
      int  d;
      bit  tmo;
      d   = int'($urandom_range(1, TO + 1));
      tmo = ($urandom_range(0, 7) == 0);
      run_sample(d, tmo);
      chk_stats("rnd");
      chk("rnd.busy", 32'(BUSY), 1);
    end

    // Asynchronous reset mid-timing.
    TRG_START = 1'b1; tick(); TRG_START = 1'b0;
    repeat (3) tick();
    RST_N = 1'b0;
    #1;
    model_reset();
    chk_stats("arst");
    chk("arst.busy", 32'(BUSY), 0);
    chk("arst.done", 32'(DONE), 0);
    ENABLE = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trg_timer_seq.md
Name: trg_timer_seq

Overview:
- Run-control sequencer for one embedded trg_timer instance. It measures the START-to-STOP trigger latency, for example L1A to LCT, over a requested number of samples.
- It drives the timer's HOLDOFF, START, STOP and CLR inputs and forces a STOP on timeout.
- It accumulates last, min, max and sample/timeout counts for the slow-control register file.

Parameters:
- TMR, 0, passed to the trg_timer instance (triple-modular-redundant counter when 1).
- TIMEOUT, 8'd250, timer value at which a measurement is aborted; legal range 1..254.
- HOLDOFF_CYC, 4, cycles HOLDOFF stays asserted after each sample before re-arming; 1..15.
- CNT_W, 16, width of the sample and timeout counters.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- ENABLE  in  1  level; run measurements while high.
- NSAMP_REQ  in  CNT_W  samples to collect per run; 0 means run forever.
- CLR_STATS  in  1  1-cycle pulse; clears stats and the timer output.
- TRG_START  in  1  start event (single-cycle pulses).
- TRG_STOP  in  1  stop event (single-cycle pulses).
- BUSY  out  1  high in any state except IDLE and DONE.
- DONE  out  1  high in DONE state.
- LAST_TIME  out  8  most recent valid latency.
- MIN_TIME  out  8  minimum valid latency.
- MAX_TIME  out  8  maximum valid latency.
- NSAMP  out  CNT_W  valid samples collected.
- NTMO  out  CNT_W  timeouts counted.

Behaviour:
- Reset values (RST_N low, asynchronous):
  - state = IDLE
  - LAST_TIME = 0, MIN_TIME = 8'hFF, MAX_TIME = 0
  - NSAMP = 0, NTMO = 0
  - BUSY = 0, DONE = 0
  - timer HOLDOFF = 1
- Timer interface:
  - HOLDOFF = 1 in IDLE, HOLD and DONE.
  - Timer START = TRG_START gated by state == ARMED.
  - Timer STOP = (TRG_STOP gated by state == TIMING) OR the forced stop.
  - Timer CLR = CLR_STATS OR (reset asserted).
- Latency definition: START sampled at edge e0 and STOP sampled at edge e0+d (d ≥ 1) gives latency = d−1. The value is valid in CAPTURE, one cycle after STOP.
- FSM states: IDLE, ARMED, TIMING, CAPTURE, HOLD, DONE.
  - IDLE: if ENABLE → ARMED. NSAMP and NTMO are cleared on this transition only if DONE was previously reached.
  - ARMED: on gated TRG_START → TIMING. TRG_STOP is ignored here. If TRG_START and TRG_STOP are high in the same cycle, START wins and the STOP is ignored (no zero-length sample).
  - TIMING:
    - On TRG_STOP → CAPTURE with valid = 1.
    - Else, when the internal shadow count reaches TIMEOUT → pulse a forced STOP → CAPTURE with valid = 0.
    - Further TRG_START pulses in this state are ignored.
  - CAPTURE (1 cycle):
    - If valid: LAST_TIME ← timer TIME; MIN/MAX update via unsigned compare; NSAMP += 1, saturating at all-ones.
    - If not valid: NTMO += 1, saturating.
    - Then → HOLD.
  - HOLD: stays HOLDOFF_CYC cycles, then:
    - → DONE if NSAMP_REQ ≠ 0 and NSAMP == NSAMP_REQ;
    - → IDLE if ENABLE == 0;
    - else → ARMED.
  - DONE: waits for ENABLE == 0, then → IDLE. Statistics are held.
- ENABLE low in ARMED or TIMING aborts the measurement → HOLD. No counter is updated; HOLD clears the timer.
- Shadow count: 8-bit, cleared in ARMED, increments in TIMING. It mirrors the timer count so that TIMEOUT is exact.
- CLR_STATS acts in any state and takes priority over a same-cycle CAPTURE update: stats are reset to their reset values and the FSM is unchanged.
- Latency 255 cannot occur because TIMEOUT ≤ 254.

Decomposition:
- Shared package trg_pkg:
  - state encoding enum trg_seq_state_t;
  - constant TRG_TIME_W = 8;
  - MIN_INIT = 8'hFF.
- One sub-module: trg_timer (existing block), instantiated as the timing datapath with TMR passed through.
- FSM, shadow counter and stats registers stay in this module.

Test Plan:
1. ENABLE=1, NSAMP_REQ=1, START pulse, STOP 6 cycles later → LAST=MIN=MAX=5, NSAMP=1, DONE=1 after HOLDOFF_CYC+1 cycles.
2. NSAMP_REQ=3, latencies 10, 3, 7 → MIN=3, MAX=10, LAST=7, NSAMP=3, NTMO=0.
3. TIMEOUT=20, START with no STOP → forced stop at shadow count 20, NTMO=1, NSAMP unchanged, LAST unchanged.
4. TRG_START and TRG_STOP in the same cycle while ARMED → TIMING entered; a STOP 2 cycles later gives LAST=1.
5. ENABLE dropped mid-TIMING → no counter change, BUSY falls after HOLDOFF_CYC cycles, state IDLE.
6. CLR_STATS coincident with CAPTURE → MIN=FF, MAX=0, NSAMP=0. Also RST_N low mid-TIMING → all outputs at reset values immediately.
